// File: rtl/fir_sched_pkg.sv
// fir_sched_pkg: shared constants, state encoding and the per-sample
// micro-sequence decoder for the dual-channel FIR scheduler.
//   Opcodes OP_*, register indices R_*, CH_BASE (first sample reg per channel),
//   state_e (scheduler FSM states), dp_op_t (one datapath instruction),
//   seq_op(step, ch) -> instruction issued at a given sequence step.
package fir_sched_pkg;

  localparam int NUM_CH   = 2;
  localparam int NUM_TAPS = 4;
  localparam int SEQ_LEN  = 12;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_COPY  = 3'b001;
  localparam logic [2:0] OP_LOAD1 = 3'b010;
  localparam logic [2:0] OP_LOAD2 = 3'b011;
  localparam logic [2:0] OP_ADD   = 3'b100;
  localparam logic [2:0] OP_SUB   = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;

  localparam logic [3:0] R_OUT   = 4'd0;
  localparam logic [3:0] R_COEF0 = 4'd9;
  localparam logic [3:0] R_TMP   = 4'd13;
  localparam logic [3:0] R_ACC   = 4'd14;
  localparam logic [3:0] CH_BASE [NUM_CH] = '{4'd1, 4'd5};

  typedef enum logic [2:0] {S_IDLE, S_COEF, S_SEQ, S_DONE, S_ABORT} state_e;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dest;
  } dp_op_t;

  // Steps 0-2 shift the channel's delay line (oldest first), step 3 loads the
  // new sample, 4-10 form F0*x0 - F1*x1 + F2*x2 - F3*x3 in R14, 11 publishes.
  function automatic dp_op_t seq_op(input logic [3:0] step, input logic ch);
    dp_op_t     o;
    logic [3:0] b;
    o = '0;
    b = CH_BASE[ch];
    case (step)
      4'd0:  begin o.op = OP_COPY;  o.src1 = b + 4'd2; o.dest = b + 4'd3; end
      4'd1:  begin o.op = OP_COPY;  o.src1 = b + 4'd1; o.dest = b + 4'd2; end
      4'd2:  begin o.op = OP_COPY;  o.src1 = b;        o.dest = b + 4'd1; end
      4'd3:  begin o.op = OP_LOAD1; o.dest = b; end
      4'd4:  begin o.op = OP_MUL; o.src1 = b;        o.src2 = R_COEF0;        o.dest = R_ACC; end
      4'd5:  begin o.op = OP_MUL; o.src1 = b + 4'd1; o.src2 = R_COEF0 + 4'd1; o.dest = R_TMP; end
      4'd6:  begin o.op = OP_SUB; o.src1 = R_ACC;    o.src2 = R_TMP;          o.dest = R_ACC; end
      4'd7:  begin o.op = OP_MUL; o.src1 = b + 4'd2; o.src2 = R_COEF0 + 4'd2; o.dest = R_TMP; end
      4'd8:  begin o.op = OP_ADD; o.src1 = R_ACC;    o.src2 = R_TMP;          o.dest = R_ACC; end
      4'd9:  begin o.op = OP_MUL; o.src1 = b + 4'd3; o.src2 = R_COEF0 + 4'd3; o.dest = R_TMP; end
      4'd10: begin o.op = OP_SUB; o.src1 = R_ACC;    o.src2 = R_TMP;          o.dest = R_ACC; end
      4'd11: begin o.op = OP_COPY; o.src1 = R_ACC;   o.dest = R_OUT; end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/fir_scheduler_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant.
//   req_i     requesting channels
//   accept_i  the current grant is taken this cycle
//   gnt_vld_o some channel is requesting
//   gnt_ch_o  granted channel
// The pointer only moves when both channels contended, so a lone request
// never steals the other channel's turn.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       gnt_vld_o,
  output logic       gnt_ch_o
);
  logic ptr_q, ptr_d;

  assign gnt_vld_o = |req_i;
  assign gnt_ch_o  = (&req_i) ? ptr_q : req_i[1];

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i && (&req_i)) ptr_d = ~gnt_ch_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/fir_scheduler.sv
// fir_scheduler: shares one FIR datapath between two sample channels.
//   clk, rst        clock, async active-high reset
//   dr[1:0], lc     synchronized data-ready / load-coefficient levels
//   overflow        datapath overflow for the op issued this cycle
//   op/src1/src2/dest, sample_sel   registered datapath instruction
//   modwait         busy indication
//   out_valid/out_ch, cnt_up        result strobe and per-channel completion
//   err             per-channel sticky error (overrun or overflow abort)
module fir_scheduler
  import fir_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] dr,
  input  logic       lc,
  input  logic       overflow,
  output logic [2:0] op,
  output logic [3:0] src1,
  output logic [3:0] src2,
  output logic [3:0] dest,
  output logic       sample_sel,
  output logic       modwait,
  output logic       out_valid,
  output logic       out_ch,
  output logic [1:0] cnt_up,
  output logic [1:0] err
);
  state_e     state_q;
  dp_op_t     dp_q;
  logic [1:0] dr_q, pending_q, pending_d, err_q, err_d;
  logic       lc_q, lc_pend_q, lc_pend_d, coef_ready_q;
  logic [1:0] coef_idx_q;
  logic [3:0] step_q;
  logic       ch_q, sel_q, out_valid_q, out_ch_q;
  logic [1:0] cnt_up_q;

  logic       gnt_vld, gnt_ch;
  logic [1:0] dr_rise, clr_mask, pend_kept;
  logic       lc_rise, in_idle, go_coef, go_seq, ovf_hit, seq_last;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (pending_q),
    .accept_i  (go_seq),
    .gnt_vld_o (gnt_vld),
    .gnt_ch_o  (gnt_ch)
  );

  always_comb begin
    dr_rise  = dr & ~dr_q;
    lc_rise  = lc & ~lc_q;
    in_idle  = (state_q == S_IDLE);
    go_coef  = in_idle && lc_pend_q;
    go_seq   = in_idle && !lc_pend_q && coef_ready_q && gnt_vld;
    ovf_hit  = (state_q == S_SEQ) && overflow && (step_q >= 4'd4) && (step_q <= 4'd10);
    seq_last = (state_q == S_SEQ) && (step_q == 4'(SEQ_LEN - 1));
    clr_mask = go_seq ? (gnt_ch ? 2'b10 : 2'b01) : 2'b00;
    // A new edge landing while the channel still has an unserved sample is an
    // overrun: the request stays single and the error is flagged.
    pend_kept = pending_q & ~clr_mask;
    pending_d = pend_kept | dr_rise;
    err_d = err_q;
    if (seq_last) err_d[ch_q] = 1'b0;
    if (ovf_hit)  err_d[ch_q] = 1'b1;
    err_d = err_d | (dr_rise & pend_kept);
    lc_pend_d = (lc_pend_q && (state_q != S_COEF)) || lc_rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      dp_q         <= '0;
      dr_q         <= '0;
      lc_q         <= 1'b0;
      pending_q    <= '0;
      lc_pend_q    <= 1'b0;
      err_q        <= '0;
      coef_ready_q <= 1'b0;
      coef_idx_q   <= '0;
      step_q       <= '0;
      ch_q         <= 1'b0;
      sel_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= 1'b0;
      cnt_up_q     <= '0;
    end else begin
      dr_q        <= dr;
      lc_q        <= lc;
      pending_q   <= pending_d;
      lc_pend_q   <= lc_pend_d;
      err_q       <= err_d;
      out_valid_q <= 1'b0;
      cnt_up_q    <= '0;
      case (state_q)
        S_IDLE: begin
          if (go_coef) begin
            state_q   <= S_COEF;
            dp_q      <= '{op: OP_LOAD2, src1: 4'd0, src2: 4'd0,
                           dest: R_COEF0 + {2'b00, coef_idx_q}};
            sel_q     <= 1'b0;
          end else if (go_seq) begin
            state_q <= S_SEQ;
            ch_q    <= gnt_ch;
            step_q  <= '0;
            dp_q    <= seq_op(4'd0, gnt_ch);
            sel_q   <= gnt_ch;
          end
        end
        S_COEF: begin
          coef_idx_q <= coef_idx_q + 2'd1;
          if (coef_idx_q == 2'(NUM_TAPS - 1)) coef_ready_q <= 1'b1;
          dp_q    <= '0;
          state_q <= S_IDLE;
        end
        S_SEQ: begin
          if (ovf_hit) begin
            state_q <= S_ABORT;
            dp_q    <= '0;
            sel_q   <= 1'b0;
          end else if (seq_last) begin
            state_q     <= S_DONE;
            dp_q        <= '0;
            sel_q       <= 1'b0;
            out_valid_q <= 1'b1;
            out_ch_q    <= ch_q;
            cnt_up_q    <= ch_q ? 2'b10 : 2'b01;
          end else begin
            step_q <= step_q + 4'd1;
            dp_q   <= seq_op(step_q + 4'd1, ch_q);
          end
        end
        default: begin
          state_q <= S_IDLE;
          dp_q    <= '0;
          sel_q   <= 1'b0;
        end
      endcase
    end
  end

  assign op         = dp_q.op;
  assign src1       = dp_q.src1;
  assign src2       = dp_q.src2;
  assign dest       = dp_q.dest;
  assign sample_sel = sel_q;
  assign modwait    = (state_q != S_IDLE) || (|pending_q) || lc_pend_q;
  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign cnt_up     = cnt_up_q;
  assign err        = err_q;
endmodule
